stack: RTL and testbench

//  - Synchronous LIFO stack with parameterised depth and width, and full/empty flags.
//  - Used as a general-purpose buffer, e.g. return-address or operand storage.
//  - Single clock domain; push/pop are level-sensitive, one operation per rising edge.

---
 rtl/stack_pkg.sv | 19 +
 rtl/stack_mem.sv | 26 ++
 rtl/stack.sv | 87 ++++++++
 tb/tb_stack.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants, count-width helper and operation decode type for the LIFO stack.
package stack_pkg;

    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_WIDTH = 4;

    // Count must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_e;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack.sv
// Synchronous LIFO stack: count register, op decode and registered data_out around stack_mem.
module stack
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_top;
    logic [WIDTH-1:0] w_rdata;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    op_e              w_op;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign w_top = r_count - CW'(1);

    // push+pop on an empty stack degrades to a plain push.
    always_comb begin
        w_op    = OP_NONE;
        w_we    = 1'b0;
        w_waddr = '0;
        if (push && pop && !empty) begin
            w_op = OP_REPLACE;
        end else if (pop && !push && !empty) begin
            w_op = OP_POP;
        end else if (push && !full) begin
            w_op = OP_PUSH;
        end
        case (w_op)
            OP_PUSH: begin
                w_we    = 1'b1;
                w_waddr = r_count[AW-1:0];
            end
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_top[AW-1:0];
            end
            default: ;
        endcase
    end

    stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (data_in),
        .i_raddr (w_top[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_count  <= '0;
            data_out <= '0;
        end else begin
            case (w_op)
                OP_PUSH:    r_count <= r_count + CW'(1);
                OP_POP: begin
                    r_count  <= r_count - CW'(1);
                    data_out <= w_rdata;
                end
                OP_REPLACE: data_out <= w_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack.sv
// Randomized and directed checking of stack against a queue-based LIFO model.
module tb_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rstN;
    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int unsigned n_total;
    int unsigned n_bad;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout;

    stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .data_in  (data_in),
        .push     (push),
        .pop      (pop),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"},  32'(data_out), 32'(m_dout));
        chk({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    endtask

    // LIFO rules applied to the queue after the edge that sampled the inputs.
    task automatic model(input logic p, input logic q, input logic [WIDTH-1:0] d);
        int unsigned n;
        n = m_q.size();
        if (p && q && n > 0) begin
            m_dout     = m_q[n-1];
            m_q[n-1]   = d;
        end else if (q && !p && n > 0) begin
            m_dout = m_q.pop_back();
        end else if (p && n < DEPTH) begin
            m_q.push_back(d);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input string tag);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        model(p, q, d);
        chk_all(tag);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        m_dout  = '0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        rstN    = 1'b0;
        #3;
        chk_all("reset");
        #9 rstN = 1'b1;
        step(1'b0, 1'b0, '0, "idle_after_reset");

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, WIDTH'(i), "fill");
        end
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 4'd9, "overflow");
        chk("overflow_full", 32'(full), 32'd1);

        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            chk("drain_lit", 32'(data_out), (i < 8) ? 32'(8 - i) : 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        step(1'b0, 1'b1, '0, "underflow");
        step(1'b1, 1'b0, 4'd1, "refill1");
        step(1'b1, 1'b0, 4'd2, "refill2");
        step(1'b0, 1'b1, '0, "refill_pop");
        chk("refill_lit", 32'(data_out), 32'd2);
        step(1'b0, 1'b1, '0, "refill_pop2");

        step(1'b1, 1'b1, 4'd3, "pp_empty");
        step(1'b1, 1'b0, 4'd5, "push5");
        step(1'b1, 1'b1, 4'd7, "replace");
        chk("replace_lit", 32'(data_out), 32'd5);
        step(1'b0, 1'b1, '0, "pop_after_replace");
        chk("replace_pop_lit", 32'(data_out), 32'd7);

        for (int i = 0; i < 400; i++) begin
            logic p;
            logic q;
            int unsigned r;
            r = $urandom_range(0, 99);
            p = (r < 45) || (r >= 85);
            q = (r >= 45);
            step(p, q, WIDTH'($urandom), "random");
        end

        // Fill partially, then assert reset between edges.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, WIDTH'($urandom), "pre_reset");
        end
        step(1'b0, 1'b1, '0, "pre_reset_pop");
        #2 rstN = 1'b0;
        #1;
        m_q.delete();
        m_dout = '0;
        chk_all("midop_reset");
        #3 rstN = 1'b1;
        step(1'b0, 1'b1, '0, "pop_after_reset");
        step(1'b1, 1'b0, 4'hA, "push_after_reset");
        step(1'b0, 1'b1, '0, "pop_after_reset2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
